// File: rtl/video_field_detect.sv
// Passive timing monitor for the scandoubler: line length, frame length, field phase, interlace and lock.
// Optional active-width measurement is built when VFD_BLANK_MEASURE_EN is defined; otherwise hactive is 0.
module video_field_detect #(
    parameter int HW         = 12,
    parameter int VW         = 11,
    parameter int HTOL       = 2,
    parameter int LOCK_LINES = 8,
    parameter int TIMEOUT    = 4095
) (
    input  logic          clk_28,
    input  logic          reset,
    input  logic          _hsync_in,
    input  logic          _vsync_in,
    input  logic          blank_in,
    output logic [HW-1:0] hperiod,
    output logic [VW-1:0] vlines,
    output logic          field,
    output logic          interlaced,
    output logic          stable,
    output logic          frame_stb,
    output logic [HW-1:0] hactive
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [HW-1:0] HMAX       = {HW{1'b1}};
    localparam logic [VW-1:0] VMAX       = {VW{1'b1}};
    localparam logic [HW-1:0] HTOL_W     = HW'(HTOL);
    localparam logic [HW-1:0] TIMEOUT_W  = HW'(TIMEOUT);
    localparam int            MW         = (LOCK_LINES > 2) ? $clog2(LOCK_LINES) : 1;
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_LINES - 1);

    logic          r_hs, r_hs_d, r_vs, r_vs_d;
    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_lcnt;
    logic [HW-1:0] r_hperiod;
    logic [VW-1:0] r_vlines;
    logic          r_field;
    logic          r_prev_valid;
    logic          r_alt;
    logic          r_interlaced;
    logic          r_stable;
    logic          r_frame_stb;
    state_t        r_state;
    logic [HW-1:0] r_ref;
    logic [MW-1:0] r_match;

    logic          w_hs_fall, w_vs_fall, w_timeout;
    logic [HW-1:0] w_hcnt_inc;
    logic [VW-1:0] w_lcnt_inc, w_lcnt_cur;
    logic [HW-1:0] w_hp_cur, w_q1, w_delta;
    logic [HW+1:0] w_hp_x3, w_q3;
    logic          w_phase, w_in_tol;
    logic [MW-1:0] w_match_inc;

    assign w_hs_fall  = ~r_hs & r_hs_d;
    assign w_vs_fall  = ~r_vs & r_vs_d;
    assign w_hcnt_inc = (r_hcnt == HMAX) ? HMAX : r_hcnt + 1'b1;
    assign w_lcnt_inc = (r_lcnt == VMAX) ? VMAX : r_lcnt + 1'b1;
    // A vsync edge coinciding with an hsync edge closes the line that just ended.
    assign w_lcnt_cur = w_hs_fall ? w_lcnt_inc : r_lcnt;
    assign w_hp_cur   = w_hs_fall ? w_hcnt_inc : r_hperiod;
    assign w_timeout  = (r_hcnt == TIMEOUT_W) && !w_hs_fall;

    assign w_q1    = w_hp_cur >> 2;
    assign w_hp_x3 = {2'b00, w_hp_cur} + {1'b0, w_hp_cur, 1'b0};
    assign w_q3    = w_hp_x3 >> 2;
    assign w_phase = !w_hs_fall && (r_hcnt >= w_q1) && ({2'b00, r_hcnt} < w_q3);

    assign w_delta     = (w_hcnt_inc >= r_ref) ? (w_hcnt_inc - r_ref) : (r_ref - w_hcnt_inc);
    assign w_in_tol    = (w_delta <= HTOL_W);
    assign w_match_inc = r_match + 1'b1;

    always_ff @(posedge clk_28 or negedge reset) begin
        if (!reset) begin
            r_hs         <= 1'b1;
            r_hs_d       <= 1'b1;
            r_vs         <= 1'b1;
            r_vs_d       <= 1'b1;
            r_hcnt       <= '0;
            r_lcnt       <= '0;
            r_hperiod    <= '0;
            r_vlines     <= '0;
            r_field      <= 1'b0;
            r_prev_valid <= 1'b0;
            r_alt        <= 1'b0;
            r_interlaced <= 1'b0;
            r_stable     <= 1'b0;
            r_frame_stb  <= 1'b0;
            r_state      <= SEARCH;
            r_ref        <= '0;
            r_match      <= '0;
        end else begin
            r_hs        <= _hsync_in;
            r_hs_d      <= r_hs;
            r_vs        <= _vsync_in;
            r_vs_d      <= r_vs;
            r_frame_stb <= w_vs_fall;
            r_hcnt      <= w_hs_fall ? '0 : w_hcnt_inc;

            if (w_hs_fall) begin
                r_hperiod <= w_hcnt_inc;
                r_lcnt    <= w_lcnt_inc;
                case (r_state)
                    SEARCH: begin
                        r_ref    <= w_hcnt_inc;
                        r_match  <= '0;
                        r_state  <= TRACK;
                        r_stable <= 1'b0;
                    end
                    TRACK: begin
                        if (!w_in_tol) begin
                            r_state <= SEARCH;
                        end else begin
                            r_match <= w_match_inc;
                            if (w_match_inc == MATCH_LAST) begin
                                r_state  <= LOCKED;
                                r_stable <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (!w_in_tol) begin
                            r_state  <= SEARCH;
                            r_stable <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= SEARCH;
                        r_stable <= 1'b0;
                    end
                endcase
            end

            if (w_vs_fall) begin
                r_vlines     <= w_lcnt_cur;
                r_lcnt       <= '0;
                r_field      <= w_phase;
                r_prev_valid <= 1'b1;
                // Interlace needs two successive field flips with a trusted predecessor frame.
                if (!r_prev_valid) begin
                    r_alt        <= 1'b0;
                    r_interlaced <= 1'b0;
                end else if (w_phase != r_field) begin
                    r_alt        <= 1'b1;
                    r_interlaced <= r_alt;
                end else begin
                    r_alt        <= 1'b0;
                    r_interlaced <= 1'b0;
                end
            end

            if (w_timeout) begin
                r_state      <= SEARCH;
                r_hperiod    <= '0;
                r_stable     <= 1'b0;
                r_interlaced <= 1'b0;
                r_field      <= 1'b0;
                r_prev_valid <= 1'b0;
                r_alt        <= 1'b0;
            end
        end
    end

    assign hperiod    = r_hperiod;
    assign vlines     = r_vlines;
    assign field      = r_field;
    assign interlaced = r_interlaced;
    assign stable     = r_stable;
    assign frame_stb  = r_frame_stb;

`ifdef VFD_BLANK_MEASURE_EN
    logic          r_blank;
    logic [HW-1:0] r_actcnt;
    logic [HW-1:0] r_hactive;

    always_ff @(posedge clk_28 or negedge reset) begin
        if (!reset) begin
            r_blank   <= 1'b1;
            r_actcnt  <= '0;
            r_hactive <= '0;
        end else begin
            r_blank <= blank_in;
            if (w_timeout) begin
                r_actcnt <= '0;
            end else if (w_hs_fall) begin
                r_hactive <= r_actcnt;
                r_actcnt  <= '0;
            end else if (!r_blank && (r_actcnt != HMAX)) begin
                r_actcnt <= r_actcnt + 1'b1;
            end
        end
    end

    assign hactive = r_hactive;
`else
    logic w_unused_blank;
    assign w_unused_blank = blank_in;
    assign hactive        = '0;
`endif

endmodule

// File: doc/video_field_detect.md
Name: video_field_detect

Overview:
- Passive monitor placed directly downstream of the amber scandoubler. It consumes the doubled _hsync/_vsync/blank outputs.
- Measures line length in clk_28 cycles and frame length in lines.
- Classifies each frame's field from the vsync phase relative to hsync, and flags interlaced and stable timing.
- Outputs feed the interlace bench checker and a future video-mode status register.

Parameters:
HW, 12, width of the horizontal period counter (clk_28 cycles)
VW, 11, width of the line counter
HTOL, 2, allowed per-line hperiod jitter in cycles
LOCK_LINES, 8, consecutive matching lines required for horizontal lock
TIMEOUT, 4095, clocks without an hsync edge before declaring loss of signal

Ports:
clk_28  input  1  28MHz system clock; all logic is on its rising edge
reset  input  1  asynchronous, active-low reset
_hsync_in  input  1  horizontal sync, active low (scandoubler output)
_vsync_in  input  1  vertical sync, active low
blank_in  input  1  video blank, active high
hperiod  output  HW  last measured line length in clocks
vlines  output  VW  lines counted in the last completed frame
field  output  1  field of the last frame (0 = even/aligned, 1 = odd/half-line)
interlaced  output  1  field has alternated for 2 consecutive frames
stable  output  1  timing locked (state LOCKED)
frame_stb  output  1  one-cycle pulse after each vsync falling edge, when outputs are updated
hactive  output  HW  non-blank clocks per line (VFD_BLANK_MEASURE_EN only, else tied 0)

Behaviour:
- Reset (reset=0, async): all outputs 0, counters 0, state SEARCH. Input sample registers are preset to 1 (sync inactive).
- Inputs are registered once. A falling edge is when the registered value is 0 and the previous registered value is 1. Edge-derived actions occur 2 clocks after the input pin changes.
- hcnt increments every clock and saturates at 2^HW-1.
- On an hsync edge:
  - hperiod <= hcnt+1; hcnt <= 0.
  - lcnt increments, saturating at 2^VW-1.
- On a vsync edge:
  - vlines <= lcnt; lcnt <= 0.
  - field <= 1 if hperiod/4 <= hcnt < 3*hperiod/4, else 0. Shifts are truncating; hperiod is the latched value.
  - frame_stb=1 in the following cycle.
- Simultaneous hsync and vsync edges in the same cycle:
  - The hsync update is applied first.
  - The vsync phase uses hcnt=0, so field=0.
  - lcnt is stored including this line, then cleared to 0.
- interlaced: set when field differs from the previous frame's field on 2 consecutive frames. Cleared on any frame whose field equals the previous one.
- Lock FSM, evaluated on hsync edges:
  - SEARCH: load ref <= new hperiod, match <= 0 -> TRACK.
  - TRACK: if |new hperiod - ref| <= HTOL, match++; otherwise return to SEARCH. When match reaches LOCK_LINES-1 -> LOCKED.
  - LOCKED: stable=1. On a line outside tolerance -> SEARCH; stable drops in the same cycle the state changes.
- Timeout: hcnt reaching TIMEOUT, in any state:
  - state -> SEARCH; hperiod <= 0; stable, interlaced and field <= 0.
  - vlines holds its value.
- Wrap/saturation: hperiod reports the saturated value 2^HW-1 if the line exceeds the counter range. vlines likewise saturates at 2^VW-1.
- First vsync after reset: vlines reports partial-frame lines. Checkers ignore the first frame_stb.

Optional Feature:
VFD_BLANK_MEASURE_EN:
- Defined: actcnt counts clocks with registered blank_in=0 between hsync edges. On an hsync edge, hactive <= actcnt and actcnt clears. Saturates at 2^HW-1 and is cleared by timeout.
- Not defined: no active counter is built and hactive is constant 0.

Test Plan:
- Lines of 908 clocks (hsync low 64), 625 lines/frame, vsync edge coincident with hsync -> hperiod=908, vlines=625, field=0, stable=1 after 8 lines, interlaced=0.
- Alternate vsync edge at hcnt=454 and hcnt=0 across frames of 312/313 lines -> field toggles 1,0,1; interlaced=1 from the 3rd frame_stb; returns to 0 after two aligned frames.
- Locked at 908, then inject one line of 911 -> SEARCH; stable=0 immediately; relock after 8 lines of 908. Jitter of 906–910 keeps stable=1.
- Hold _hsync_in=1 for 5000 clocks -> at hcnt=4095: hperiod=0, stable=0, interlaced=0; vlines unchanged.
- Assert reset mid-frame with hsync low -> all outputs 0 asynchronously. After release, the first vsync frame_stb is ignored and the second reports the full 625.
- With VFD_BLANK_MEASURE_EN, blank_in low for 720 clocks per 908-clock line -> hactive=720. Without the macro, hactive=0.
